// File: rtl/button_pulse_gen_if.sv
// Button-side signal bundle for button_pulse_gen: the raw button level in and
// the debounced level plus event pulses out.
interface button_pulse_gen_if;
   logic btn_in;
   logic pressed;
   logic press_pulse;
   logic release_pulse;
   logic long_pulse;

   // Drives the raw button and observes the debounced events.
   modport master (
      output btn_in,
      input  pressed,
      input  press_pulse,
      input  release_pulse,
      input  long_pulse
   );

   // The debouncer itself.
   modport slave (
      input  btn_in,
      output pressed,
      output press_pulse,
      output release_pulse,
      output long_pulse
   );
endinterface

// File: rtl/button_pulse_gen.sv
// Push-button debouncer: synchronizes a bouncing raw level, accepts a change only
// after DB_CYCLES stable samples, and emits press/release/long-hold pulses.
module button_pulse_gen #(
   parameter int unsigned DB_CYCLES   = 1000,
   parameter int unsigned HOLD_CYCLES = 50000,
   parameter int unsigned CNT_W       = 20
) (
   input logic                clk,
   input logic                rst,
   button_pulse_gen_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   // Parking hold_cnt one past HOLD_LAST marks the long pulse as already spent.
   localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_CYCLES);

   logic             sync1_q;
   logic             btn_s_q;
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] hold_cnt_q;
   logic             pressed_q;
   logic             press_pulse_q;
   logic             release_pulse_q;
   logic             long_pulse_q;

   // Two-flop synchronizer; the only logic that touches the raw button.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         btn_s_q <= 1'b0;
      end else begin
         sync1_q <= bus.btn_in;
         btn_s_q <= sync1_q;
      end
   end

   // Debounce FSM with registered level and pulse outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         cnt_q           <= CNT_ZERO;
         hold_cnt_q      <= CNT_ZERO;
         pressed_q       <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         long_pulse_q    <= 1'b0;
      end else begin
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         long_pulse_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= CNT_ZERO;
               if (btn_s_q) begin
                  state_q <= PRESS_WAIT;
               end else begin
                  state_q <= IDLE;
               end
            end
            PRESS_WAIT: begin
               if (!btn_s_q) begin
                  state_q <= IDLE;
                  cnt_q   <= CNT_ZERO;
               end else if (cnt_q == DB_LAST) begin
                  state_q       <= HELD;
                  cnt_q         <= CNT_ZERO;
                  hold_cnt_q    <= CNT_ZERO;
                  pressed_q     <= 1'b1;
                  press_pulse_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            HELD: begin
               if (!btn_s_q) begin
                  state_q <= RELEASE_WAIT;
                  cnt_q   <= CNT_ZERO;
               end else if (hold_cnt_q < HOLD_LAST) begin
                  hold_cnt_q <= hold_cnt_q + CNT_ONE;
               end else if (hold_cnt_q == HOLD_LAST) begin
                  hold_cnt_q   <= HOLD_SAT;
                  long_pulse_q <= 1'b1;
               end else begin
                  hold_cnt_q <= hold_cnt_q;
               end
            end
            RELEASE_WAIT: begin
               // A bounce back high resumes HELD with hold_cnt untouched.
               if (btn_s_q) begin
                  state_q <= HELD;
                  cnt_q   <= CNT_ZERO;
               end else if (cnt_q == DB_LAST) begin
                  state_q         <= IDLE;
                  cnt_q           <= CNT_ZERO;
                  pressed_q       <= 1'b0;
                  release_pulse_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q    <= IDLE;
               cnt_q      <= CNT_ZERO;
               hold_cnt_q <= CNT_ZERO;
               pressed_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pressed       = pressed_q;
   assign bus.press_pulse   = press_pulse_q;
   assign bus.release_pulse = release_pulse_q;
   assign bus.long_pulse    = long_pulse_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Self-checking bench for button_pulse_gen: directed scenarios with literal
// expectations plus randomized button/reset activity against a behavioural model.
module tb_button_pulse_gen;
   localparam int DB   = 4;
   localparam int HOLD = 20;
   localparam int W    = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   button_pulse_gen_if bus ();

   button_pulse_gen #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .CNT_W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Behavioural model: a change is accepted after DB+1 consecutive disagreeing
   // synchronized samples; long fires on the HOLD-th steady-high sample of a press.
   logic       m_s1, m_s2, m_level, m_long_done;
   int         m_run, m_hold;
   logic [3:0] m_exp;     // {pressed, press_pulse, release_pulse, long_pulse}
   bit         chk_en;
   bit         lit_en;
   logic [3:0] lit_exp;
   int         cyc;
   int         n_cmp, n_err;

   task automatic model_step(input logic r, input logic b);
      logic bs;
      logic p, rl, lg;
      bit   steady_held;
      p = 1'b0; rl = 1'b0; lg = 1'b0;
      if (r) begin
         m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0;
         m_run = 0; m_hold = 0; m_long_done = 1'b0;
      end else begin
         bs   = m_s2;
         m_s2 = m_s1;
         m_s1 = b;
         steady_held = (m_level == 1'b1) && (m_run == 0);
         if (bs != m_level) begin
            m_run = m_run + 1;
            if (m_run == DB + 1) begin
               m_level = bs;
               m_run   = 0;
               if (bs) begin
                  p = 1'b1; m_hold = 0; m_long_done = 1'b0;
               end else begin
                  rl = 1'b1;
               end
            end
         end else begin
            m_run = 0;
            if (steady_held && bs) begin
               m_hold = m_hold + 1;
               if (m_hold == HOLD && !m_long_done) begin
                  lg = 1'b1; m_long_done = 1'b1;
               end
            end
         end
      end
      m_exp = {m_level, p, rl, lg};
   endtask

   // One clock: drive on the falling edge, advance the model on the rising edge.
   task automatic step(input logic r, input logic b, input bit le, input logic [3:0] le_exp);
      @(negedge clk);
      rst        = r;
      bus.btn_in = b;
      @(posedge clk);
      model_step(r, b);
      lit_en  = le;
      lit_exp = le_exp;
      cyc     = cyc + 1;
   endtask

   // Compare process: model every cycle, literal expectations where given.
   initial begin
      logic [3:0] act;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            act   = {bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse};
            n_cmp = n_cmp + 1;
            if (act !== m_exp) begin
               n_err = n_err + 1;
               $display("FAIL model cyc=%0d got {prs,pp,rp,lp}=%b expected %b", cyc, act, m_exp);
            end
            if (lit_en) begin
               n_cmp = n_cmp + 1;
               if (act !== lit_exp) begin
                  n_err = n_err + 1;
                  $display("FAIL literal cyc=%0d got {prs,pp,rp,lp}=%b expected %b", cyc, act, lit_exp);
               end
            end
         end
      end
   end

   initial begin
      logic lvl;
      int   seg_left;
      n_cmp = 0; n_err = 0; cyc = 0;
      chk_en = 1'b0; lit_en = 1'b0; lit_exp = 4'b0000;
      m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_long_done = 1'b0;
      m_run = 0; m_hold = 0; m_exp = 4'b0000;
      rst = 1'b1; bus.btn_in = 1'b0;

      step(1'b1, 1'b0, 1'b0, 4'b0000);
      chk_en = 1'b1;
      step(1'b1, 1'b0, 1'b1, 4'b0000);
      step(1'b0, 1'b0, 1'b1, 4'b0000);

      // Clean press, long hold, clean release (press k=6, long k=26, release k=46).
      for (int k = 0; k < 50; k++) begin
         step(1'b0, (k < 40), 1'b1,
              {(k >= 6 && k < 46), (k == 6), (k == 46), (k == 26)});
      end

      // Press bounce: never accepted.
      for (int k = 0; k < 12; k++) begin
         step(1'b0, (k < 3), 1'b1, 4'b0000);
      end

      // Release glitch while held: no release until the real one at k=26.
      for (int k = 0; k < 30; k++) begin
         step(1'b0, (k < 10) || (k >= 12 && k < 20), 1'b1,
              {(k >= 6 && k < 26), (k == 6), (k == 26), 1'b0});
      end

      // Reset while held, button still high: silent reset, then a fresh press.
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b1, 1'b1, {(k >= 6), (k == 6), 2'b00});
      end
      step(1'b1, 1'b1, 1'b1, 4'b0000);
      for (int j = 0; j < 12; j++) begin
         step(1'b0, 1'b1, 1'b1, {(j >= 6), (j == 6), 2'b00});
      end
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b0, 1'b0, 4'b0000);
      end

      // Randomized segments of bouncing and steady levels with rare resets.
      seg_left = 0;
      lvl      = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (seg_left == 0) begin
            lvl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) seg_left = $urandom_range(1, 3);
            else                           seg_left = $urandom_range(4, 45);
         end
         seg_left = seg_left - 1;
         step(($urandom_range(0, 99) == 0), lvl, 1'b0, 4'b0000);
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
